axi_bw_monitor: RTL and testbench
=================================

// Module: axi_bw_monitor
// PURPOSE
// - Passive AXI4 observer on one master/slave interface; never drives or stalls the bus.
// - Tracks outstanding AR/AW transactions, counts transferred bytes and busy cycles, and accumulates in-flight occupancy (average latency = occupancy / txns).
// - Used by traffic-generator nodes to report per-interface bandwidth at end of simulation.
// PARAMETERS
// - req_t       (type)   AXI request struct: aw, w, ar, *_valid, b_ready, r_ready.
// - rsp_t       (type)   AXI response struct: b, r, *_ready, b_valid, r_valid.
// - AxiIdWidth  (4)      ID width; sizes the per-ID outstanding table (2**AxiIdWidth entries).
// - Name        ("bw")   String prefix for the report.
// - CntWidth    (64)     Width of byte, cycle and occupancy counters.
// - InFlWidth   (16)     Width of the in-flight outputs and the per-ID counters.
// PORTS
// - clk_i           in   1          Clock.
// - rst_i           in   1          Asynchronous active-high reset.
// - en_i            in   1          Measurement enable.
// - end_of_sim_i    in   1          Closes the measurement window.
// - req_i           in   req_t      Observed request.
// - rsp_i           in   rsp_t      Observed response.
// - ar_in_flight_o  out  InFlWidth  Outstanding reads.
// - aw_in_flight_o  out  InFlWidth  Outstanding writes.
// - rd_bytes_o      out  CntWidth   Read bytes transferred.
// - wr_bytes_o      out  CntWidth   Write bytes transferred (strobe-weighted).
// - cycles_o        out  CntWidth   Cycles in the measurement window.
// - rd_occ_o        out  CntWidth   Sum over cycles of ar_in_flight.
// - wr_occ_o        out  CntWidth   Sum over cycles of aw_in_flight.
// - rd_txns_o       out  CntWidth   Completed reads (R last).
// - wr_txns_o       out  CntWidth   Completed writes (B).
// - err_o           out  1          Sticky protocol error.
// BEHAVIOUR
// - Reset: every output and internal counter is 0; report_done is 0.
// - Handshake: a channel handshake is valid&&ready sampled at posedge clk_i.
// - Active = en_i && !stopped. stopped sets on the first posedge where end_of_sim_i=1 and never clears except on reset.
// - Read in-flight: +1 on an AR handshake; -1 on an R handshake with r.last. Both in the same cycle: net 0.
// - Write in-flight: +1 on an AW handshake; -1 on a B handshake; same simultaneity rule.
// - Per-ID table: the AR/AW counter is indexed by id; the R-last/B counter is indexed by the response id.
// - Response on an id whose counter is 0: the counter stays 0 (no underflow) and err_o sets.
// - Increment when a counter is at its max: the counter holds and err_o sets.
// - err_o is sticky.
// - In-flight tracking runs only while active. Outputs are registered: 1-cycle latency after the handshake.
// - Bytes:
//   - rd_bytes += $bits(r.data)/8 per R beat.
//   - wr_bytes += popcount(w.strb) per W beat.
//   - Read and write beats in the same cycle both count.
// - cycles_o +1 per active cycle. rd_occ/wr_occ add the current (pre-update) in-flight value each active cycle.
// - rd_txns/wr_txns +1 per completion while active.
// - All CntWidth counters saturate at all-ones (no wrap).
// - en_i low: every counter holds; the bus is ignored.
// - end_of_sim_i: all counters freeze the following cycle; outputs stay stable.
// - Reset mid-operation: immediate clear of all state, including the per-ID table.
// CONFIGURATION
// - AXI_BW_MONITOR_REPORT_EN defined:
//   - On the first cycle stopped=1, emit one $display with Name, cycles, rd/wr bytes, bytes/cycle (real), average latency = occ/txns (0 if txns=0) and err.
//   - The report prints once per reset.
// - Undefined: no $display and no real arithmetic; counters and outputs behave identically.
// STRUCTURE
// - Shared package axi_bw_monitor_pkg:
//   - popcount function.
//   - saturating-add function.
//   - report-format helper.
// - One sub-module, axi_bw_inflight_tracker, instantiated twice (read, write):
//   - Inputs: inc valid/id, dec valid/id.
//   - Contains the per-ID table, the total count and the error detect.
// TESTING
// - AR id=2 handshake at cycle 5, R last id=2 at cycle 9 -> ar_in_flight_o 1 for cycles 6..9, 0 at 10; rd_occ_o=4; rd_txns_o=1.
// - 64-bit data; 4 R beats and 2 W beats with strb=8'h0F -> rd_bytes_o=32, wr_bytes_o=8.
// - B on id=3 with none outstanding -> err_o=1 next cycle, aw_in_flight_o stays 0.
// - Same-cycle AW and B (on another outstanding id) -> aw_in_flight_o unchanged.
// - en_i=0 for 10 cycles with traffic, then end_of_sim_i=1 -> cycles_o and byte counts hold; with REPORT_EN exactly one report line.
// - rst_i pulse asynchronously mid-burst -> all outputs 0 immediately, tracking restarts cleanly.

Source files
------------

// File: rtl/axi_bw_monitor_pkg.sv
// Shared types and helpers for the AXI bandwidth monitor.
// Optional feature macro: AXI_BW_MONITOR_REPORT_EN enables the end-of-window report helper.
package axi_bw_monitor_pkg;

  localparam int unsigned MaxCntWidth  = 64;
  localparam int unsigned MaxStrbWidth = 128;

  // Default AXI4 channel payloads: 4-bit id, 32-bit address, 64-bit data
  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } axi_ax_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ax_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    axi_b_t  b;
    logic    b_valid;
    axi_r_t  r;
    logic    r_valid;
  } axi_rsp_t;

  // Number of set bits in a (zero-extended) strobe vector
  function automatic logic [MaxCntWidth-1:0] popcount(input logic [MaxStrbWidth-1:0] v);
    logic [MaxCntWidth-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < MaxStrbWidth; i++) begin
      n = n + MaxCntWidth'(v[i]);
    end
    return n;
  endfunction

  // a + b clamped to the all-ones value of a width-bit counter
  function automatic logic [MaxCntWidth-1:0] sat_add(input logic [MaxCntWidth-1:0] a,
                                                     input logic [MaxCntWidth-1:0] b,
                                                     input int unsigned width);
    logic [MaxCntWidth:0] sum;
    logic [MaxCntWidth:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = ((MaxCntWidth+1)'(1) << width) - (MaxCntWidth+1)'(1);
    return (sum > lim) ? lim[MaxCntWidth-1:0] : sum[MaxCntWidth-1:0];
  endfunction

`ifdef AXI_BW_MONITOR_REPORT_EN
  // One-line bandwidth/latency summary; ratios are 0 when the divisor is 0
  function automatic string report_line(input string name,
                                        input logic [63:0] cycles,
                                        input logic [63:0] rd_bytes,
                                        input logic [63:0] wr_bytes,
                                        input logic [63:0] rd_occ,
                                        input logic [63:0] wr_occ,
                                        input logic [63:0] rd_txns,
                                        input logic [63:0] wr_txns,
                                        input logic        err);
    real rd_bpc, wr_bpc, rd_lat, wr_lat;
    rd_bpc = (cycles  == 0) ? 0.0 : real'(rd_bytes) / real'(cycles);
    wr_bpc = (cycles  == 0) ? 0.0 : real'(wr_bytes) / real'(cycles);
    rd_lat = (rd_txns == 0) ? 0.0 : real'(rd_occ) / real'(rd_txns);
    wr_lat = (wr_txns == 0) ? 0.0 : real'(wr_occ) / real'(wr_txns);
    return $sformatf("[%s] cycles=%0d rd_bytes=%0d wr_bytes=%0d rd_bpc=%.3f wr_bpc=%.3f rd_lat=%.2f wr_lat=%.2f err=%0b",
                     name, cycles, rd_bytes, wr_bytes, rd_bpc, wr_bpc, rd_lat, wr_lat, err);
  endfunction
`endif

endpackage

// File: rtl/axi_bw_inflight_tracker.sv
// Per-ID outstanding-transaction table with a total count and error detection.
module axi_bw_inflight_tracker #(
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                inc_valid_i,
  input  logic [IdWidth-1:0]  inc_id_i,
  input  logic                dec_valid_i,
  input  logic [IdWidth-1:0]  dec_id_i,
  output logic [CntWidth-1:0] total_o,
  output logic                err_o
);

  localparam int unsigned NumIds = 2 ** IdWidth;

  logic [CntWidth-1:0] tbl_q [NumIds];
  logic [CntWidth-1:0] inc_cnt, dec_cnt;
  logic                same_id, inc_ok, dec_ok, tot_up, tot_dn, tot_ovf;

  // Qualify increment/decrement against the current table contents
  always_comb begin
    inc_cnt = tbl_q[inc_id_i];
    dec_cnt = tbl_q[dec_id_i];
    same_id = inc_valid_i && dec_valid_i && (inc_id_i == dec_id_i);
    dec_ok  = dec_valid_i && (dec_cnt != '0);
    // A full entry may still accept an increment when the same entry retires one this cycle
    inc_ok  = inc_valid_i && ((inc_cnt != '1) || (same_id && dec_ok));
    tot_up  = inc_ok && !dec_ok;
    tot_dn  = dec_ok && !inc_ok;
    tot_ovf = tot_up && (total_o == '1);
    err_o   = (inc_valid_i && !inc_ok) || (dec_valid_i && !dec_ok) || tot_ovf;
  end

  // Per-ID counters and total
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        tbl_q[i] <= '0;
      end
      total_o <= '0;
    end else begin
      if (same_id) begin
        if (inc_ok && !dec_ok) tbl_q[inc_id_i] <= inc_cnt + CntWidth'(1);
      end else begin
        if (inc_ok) tbl_q[inc_id_i] <= inc_cnt + CntWidth'(1);
        if (dec_ok) tbl_q[dec_id_i] <= dec_cnt - CntWidth'(1);
      end
      if (tot_up && !tot_ovf) total_o <= total_o + CntWidth'(1);
      else if (tot_dn)        total_o <= total_o - CntWidth'(1);
    end
  end

endmodule

// File: rtl/axi_bw_monitor.sv
// Passive AXI4 bandwidth/latency monitor for one interface.
// Optional feature macro: AXI_BW_MONITOR_REPORT_EN prints one summary line when the window closes.
module axi_bw_monitor
  import axi_bw_monitor_pkg::*;
#(
  parameter type         req_t      = axi_req_t,
  parameter type         rsp_t      = axi_rsp_t,
  parameter int unsigned AxiIdWidth = 4,
  parameter string       Name       = "bw",
  parameter int unsigned CntWidth   = 64,
  parameter int unsigned InFlWidth  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic                 end_of_sim_i,
  input  req_t                 req_i,
  input  rsp_t                 rsp_i,
  output logic [InFlWidth-1:0] ar_in_flight_o,
  output logic [InFlWidth-1:0] aw_in_flight_o,
  output logic [CntWidth-1:0]  rd_bytes_o,
  output logic [CntWidth-1:0]  wr_bytes_o,
  output logic [CntWidth-1:0]  cycles_o,
  output logic [CntWidth-1:0]  rd_occ_o,
  output logic [CntWidth-1:0]  wr_occ_o,
  output logic [CntWidth-1:0]  rd_txns_o,
  output logic [CntWidth-1:0]  wr_txns_o,
  output logic                 err_o
);

  localparam int unsigned RdBeatBytes = $bits(rsp_i.r.data) / 8;

  logic stopped_q, active;
  logic ar_hs, aw_hs, w_hs, r_hs, b_hs, r_last_hs;
  logic rd_err, wr_err;
  logic unused_bits;

  assign unused_bits = ^{req_i, rsp_i};

  function automatic logic [CntWidth-1:0] sat(input logic [CntWidth-1:0] a,
                                              input logic [CntWidth-1:0] b);
    logic [MaxCntWidth-1:0] s;
    s = sat_add(MaxCntWidth'(a), MaxCntWidth'(b), CntWidth);
    return s[CntWidth-1:0];
  endfunction

  assign active    = en_i && !stopped_q;
  assign ar_hs     = req_i.ar_valid && rsp_i.ar_ready;
  assign aw_hs     = req_i.aw_valid && rsp_i.aw_ready;
  assign w_hs      = req_i.w_valid  && rsp_i.w_ready;
  assign r_hs      = rsp_i.r_valid  && req_i.r_ready;
  assign b_hs      = rsp_i.b_valid  && req_i.b_ready;
  assign r_last_hs = r_hs && rsp_i.r.last;

  axi_bw_inflight_tracker #(
    .IdWidth  (AxiIdWidth),
    .CntWidth (InFlWidth)
  ) u_rd_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_valid_i (active && ar_hs),
    .inc_id_i    (req_i.ar.id),
    .dec_valid_i (active && r_last_hs),
    .dec_id_i    (rsp_i.r.id),
    .total_o     (ar_in_flight_o),
    .err_o       (rd_err)
  );

  axi_bw_inflight_tracker #(
    .IdWidth  (AxiIdWidth),
    .CntWidth (InFlWidth)
  ) u_wr_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .inc_valid_i (active && aw_hs),
    .inc_id_i    (req_i.aw.id),
    .dec_valid_i (active && b_hs),
    .dec_id_i    (rsp_i.b.id),
    .total_o     (aw_in_flight_o),
    .err_o       (wr_err)
  );

  // Window latch: closes on the first end_of_sim_i edge, reopens only on reset
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) stopped_q <= 1'b0;
    else if (end_of_sim_i) stopped_q <= 1'b1;
  end

  // Saturating statistics; occupancy accumulates the pre-update in-flight value
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_bytes_o <= '0;
      wr_bytes_o <= '0;
      cycles_o   <= '0;
      rd_occ_o   <= '0;
      wr_occ_o   <= '0;
      rd_txns_o  <= '0;
      wr_txns_o  <= '0;
    end else if (active) begin
      cycles_o <= sat(cycles_o, CntWidth'(1));
      rd_occ_o <= sat(rd_occ_o, CntWidth'(ar_in_flight_o));
      wr_occ_o <= sat(wr_occ_o, CntWidth'(aw_in_flight_o));
      if (r_hs)      rd_bytes_o <= sat(rd_bytes_o, CntWidth'(RdBeatBytes));
      if (w_hs)      wr_bytes_o <= sat(wr_bytes_o, CntWidth'(popcount(MaxStrbWidth'(req_i.w.strb))));
      if (r_last_hs) rd_txns_o  <= sat(rd_txns_o, CntWidth'(1));
      if (b_hs)      wr_txns_o  <= sat(wr_txns_o, CntWidth'(1));
    end
  end

  // Sticky protocol error (tracker errors are already gated by active)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= err_o | rd_err | wr_err;
  end

`ifdef AXI_BW_MONITOR_REPORT_EN
  logic report_done_q;

  // Single report on the first cycle after the window closes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      report_done_q <= 1'b0;
    end else if (stopped_q && !report_done_q) begin
      $display("%s", report_line(Name, 64'(cycles_o), 64'(rd_bytes_o), 64'(wr_bytes_o),
                                 64'(rd_occ_o), 64'(wr_occ_o), 64'(rd_txns_o),
                                 64'(wr_txns_o), err_o));
      report_done_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_bw_monitor.sv
// Directed scoreboard bench for axi_bw_monitor (narrow counters to reach saturation).
module tb_axi_bw_monitor;
  import axi_bw_monitor_pkg::*;

  localparam int unsigned CW   = 10;
  localparam int unsigned IW   = 4;
  localparam logic [63:0] CMAX = 64'd1023;
  localparam int          IMAX = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  logic eos = 1'b0;
  axi_req_t req;
  axi_rsp_t rsp;

  logic [IW-1:0] ar_if, aw_if;
  logic [CW-1:0] rd_bytes, wr_bytes, cycles, rd_occ, wr_occ, rd_txns, wr_txns;
  logic          err;

  axi_bw_monitor #(
    .req_t      (axi_req_t),
    .rsp_t      (axi_rsp_t),
    .AxiIdWidth (4),
    .Name       ("tb"),
    .CntWidth   (CW),
    .InFlWidth  (IW)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (en),
    .end_of_sim_i   (eos),
    .req_i          (req),
    .rsp_i          (rsp),
    .ar_in_flight_o (ar_if),
    .aw_in_flight_o (aw_if),
    .rd_bytes_o     (rd_bytes),
    .wr_bytes_o     (wr_bytes),
    .cycles_o       (cycles),
    .rd_occ_o       (rd_occ),
    .wr_occ_o       (wr_occ),
    .rd_txns_o      (rd_txns),
    .wr_txns_o      (wr_txns),
    .err_o          (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned sel;
    logic [63:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: 0 ar_if 1 aw_if 2 rd_bytes 3 wr_bytes 4 cycles 5 rd_occ 6 wr_occ 7 rd_txns 8 wr_txns 9 err
  logic [63:0] m_out [10];
  int          rd_tab [16];
  int          wr_tab [16];
  bit          m_stopped;
  string       names [10] = '{"ar_if", "aw_if", "rd_bytes", "wr_bytes", "cycles",
                              "rd_occ", "wr_occ", "rd_txns", "wr_txns", "err"};

  function automatic logic [63:0] observe(input int unsigned s);
    case (s)
      0: return 64'(ar_if);
      1: return 64'(aw_if);
      2: return 64'(rd_bytes);
      3: return 64'(wr_bytes);
      4: return 64'(cycles);
      5: return 64'(rd_occ);
      6: return 64'(wr_occ);
      7: return 64'(rd_txns);
      8: return 64'(wr_txns);
      default: return 64'(err);
    endcase
  endfunction

  function automatic logic [63:0] sat(input logic [63:0] v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic push(input string tag, input int unsigned sel, input logic [63:0] e);
    sb.push_back('{tag, sel, e});
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      checks++;
      assert (obs === e.exp) else begin
        errors++;
        $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 10; i++) m_out[i] = '0;
    for (int i = 0; i < 16; i++) begin
      rd_tab[i] = 0;
      wr_tab[i] = 0;
    end
    m_stopped = 1'b0;
  endtask

  task automatic track(input bit is_rd, input bit inc, input int iid, input bit dec, input int did);
    int          t [16];
    logic [63:0] tot;
    bit          inc_ok, dec_ok;
    if (is_rd) begin t = rd_tab; tot = m_out[0]; end
    else       begin t = wr_tab; tot = m_out[1]; end
    dec_ok = dec && (t[did] > 0);
    inc_ok = inc && ((t[iid] < IMAX) || (dec_ok && did == iid));
    if ((inc && !inc_ok) || (dec && !dec_ok)) m_out[9] = 64'd1;
    if (dec_ok) t[did] = t[did] - 1;
    if (inc_ok) t[iid] = t[iid] + 1;
    if (inc_ok && !dec_ok) begin
      if (tot == 64'(IMAX)) m_out[9] = 64'd1;
      else tot = tot + 1;
    end else if (dec_ok && !inc_ok) begin
      tot = tot - 1;
    end
    if (is_rd) begin rd_tab = t; m_out[0] = tot; end
    else       begin wr_tab = t; m_out[1] = tot; end
  endtask

  task automatic model_step();
    bit act, ar_hs, aw_hs, w_hs, r_hs, b_hs;
    act   = en && !m_stopped;
    ar_hs = req.ar_valid && rsp.ar_ready;
    aw_hs = req.aw_valid && rsp.aw_ready;
    w_hs  = req.w_valid && rsp.w_ready;
    r_hs  = rsp.r_valid && req.r_ready;
    b_hs  = rsp.b_valid && req.b_ready;
    if (act) begin
      m_out[4] = sat(m_out[4] + 1);
      m_out[5] = sat(m_out[5] + m_out[0]);
      m_out[6] = sat(m_out[6] + m_out[1]);
      if (r_hs) m_out[2] = sat(m_out[2] + 8);
      if (w_hs) m_out[3] = sat(m_out[3] + 64'($countones(req.w.strb)));
      if (r_hs && rsp.r.last) m_out[7] = sat(m_out[7] + 1);
      if (b_hs) m_out[8] = sat(m_out[8] + 1);
      track(1'b1, ar_hs, int'(req.ar.id), r_hs && rsp.r.last, int'(rsp.r.id));
      track(1'b0, aw_hs, int'(req.aw.id), b_hs, int'(rsp.b.id));
    end
    if (eos) m_stopped = 1'b1;
  endtask

  // Model the coming edge, queue full expected state, clock, then compare
  task automatic tick();
    model_step();
    for (int unsigned s = 0; s < 10; s++) push(names[s], s, m_out[s]);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic idle_bus();
    req          = '0;
    rsp          = '0;
    rsp.aw_ready = 1'b1;
    rsp.ar_ready = 1'b1;
    rsp.w_ready  = 1'b1;
    req.b_ready  = 1'b1;
    req.r_ready  = 1'b1;
  endtask

  task automatic set_ar(input logic [3:0] id);
    req.ar_valid = 1'b1; req.ar.id = id; req.ar.addr = 32'h1000;
  endtask
  task automatic set_aw(input logic [3:0] id);
    req.aw_valid = 1'b1; req.aw.id = id; req.aw.addr = 32'h2000;
  endtask
  task automatic set_r(input logic [3:0] id, input logic last);
    rsp.r_valid = 1'b1; rsp.r.id = id; rsp.r.last = last; rsp.r.data = 64'hA5A5_5A5A_0123_4567;
  endtask
  task automatic set_w(input logic [7:0] strb);
    req.w_valid = 1'b1; req.w.strb = strb; req.w.data = 64'hFFFF_0000_FFFF_0000;
  endtask
  task automatic set_b(input logic [3:0] id);
    rsp.b_valid = 1'b1; rsp.b.id = id;
  endtask

  logic [63:0] snap_cyc, snap_rb, snap_wb, snap_ar;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_bus();
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int unsigned s = 0; s < 10; s++) push({"reset_", names[s]}, s, 64'd0);
    drain();
    rst = 1'b0;
    en  = 1'b1;

    // AR id=2 then R last id=2 four cycles later
    repeat (4) begin idle_bus(); tick(); end
    idle_bus(); set_ar(4'd2); push("lat_ar_if_up", 0, 64'd1); tick();
    repeat (3) begin idle_bus(); push("lat_ar_if_hold", 0, 64'd1); tick(); end
    idle_bus(); set_r(4'd2, 1'b1);
    push("lat_ar_if_down", 0, 64'd0); push("lat_rd_occ", 5, 64'd4); push("lat_rd_txns", 7, 64'd1);
    tick();

    // Four R beats (64-bit) alongside two W beats with strb 0x0F
    idle_bus(); set_ar(4'd0); tick();
    idle_bus(); set_r(4'd0, 1'b0); set_w(8'h0F); tick();
    idle_bus(); set_r(4'd0, 1'b0); set_w(8'h0F); tick();
    idle_bus(); set_r(4'd0, 1'b0); tick();
    idle_bus(); set_r(4'd0, 1'b1);
    push("bytes_rd", 2, 64'd40); push("bytes_wr", 3, 64'd8); push("bytes_rd_txns", 7, 64'd2);
    tick();

    // AW and B on another outstanding id in the same cycle
    idle_bus(); set_aw(4'd4); push("simul_aw_if_1", 1, 64'd1); tick();
    idle_bus(); set_aw(4'd5); set_b(4'd4); push("simul_aw_if_same", 1, 64'd1); tick();
    idle_bus(); set_b(4'd5);
    push("simul_aw_if_0", 1, 64'd0); push("simul_err", 9, 64'd0); push("simul_wr_txns", 8, 64'd2);
    tick();

    // Fill one id to its maximum, then overflow it
    for (int i = 0; i < IMAX; i++) begin idle_bus(); set_ar(4'd1); tick(); end
    push("max_ar_if", 0, 64'(IMAX)); push("max_err_clear", 9, 64'd0); drain();
    idle_bus(); set_ar(4'd1);
    push("max_ar_if_hold", 0, 64'(IMAX)); push("max_err_set", 9, 64'd1); tick();
    for (int i = 0; i < IMAX; i++) begin idle_bus(); set_r(4'd1, 1'b1); tick(); end
    push("max_ar_if_drained", 0, 64'd0); drain();

    // Saturate the read byte counter
    for (int i = 0; i < 128; i++) begin idle_bus(); set_r(4'd0, 1'b0); tick(); end
    push("sat_rd_bytes", 2, CMAX); drain();

    // Asynchronous reset in the middle of a burst
    idle_bus(); set_ar(4'd3); set_r(4'd0, 1'b0); set_w(8'hFF);
    #3;
    rst = 1'b1;
    #1;
    for (int unsigned s = 0; s < 10; s++) push({"arst_", names[s]}, s, 64'd0);
    drain();
    model_reset();
    @(posedge clk);
    #1;
    for (int unsigned s = 0; s < 10; s++) push({"arst_hold_", names[s]}, s, 64'd0);
    drain();
    rst = 1'b0;

    // Tracking restarts cleanly
    idle_bus(); tick();
    idle_bus(); set_ar(4'd2); push("restart_ar_if", 0, 64'd1); tick();
    idle_bus(); set_r(4'd2, 1'b1);
    push("restart_ar_if_0", 0, 64'd0); push("restart_txns", 7, 64'd1); push("restart_cycles", 4, 64'd3);
    tick();

    // B with nothing outstanding on id 3
    idle_bus(); set_b(4'd3);
    push("b_noout_err", 9, 64'd1); push("b_noout_aw_if", 1, 64'd0); tick();

    // Enable low with traffic: everything holds
    snap_cyc = m_out[4]; snap_rb = m_out[2]; snap_wb = m_out[3];
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      idle_bus(); set_ar(4'd6); set_r(4'd0, 1'b0); set_w(8'hFF); set_aw(4'd7);
      if (i == 9) begin
        push("en0_cycles", 4, snap_cyc); push("en0_rd_bytes", 2, snap_rb);
        push("en0_wr_bytes", 3, snap_wb); push("en0_ar_if", 0, 64'd0);
      end
      tick();
    end

    // Close the window; the closing cycle still counts, then everything freezes
    en = 1'b1; eos = 1'b1;
    idle_bus(); set_ar(4'd7); set_r(4'd0, 1'b0);
    push("eos_cycles_last", 4, snap_cyc + 1); push("eos_ar_if_last", 0, 64'd1);
    tick();
    eos = 1'b0;
    snap_cyc = m_out[4]; snap_rb = m_out[2]; snap_ar = m_out[0];
    for (int i = 0; i < 5; i++) begin
      idle_bus(); set_ar(4'd8); set_r(4'd0, 1'b0); set_w(8'h0F);
      if (i == 4) begin
        push("eos_cycles_frozen", 4, snap_cyc); push("eos_rd_bytes_frozen", 2, snap_rb);
        push("eos_ar_if_frozen", 0, snap_ar);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
